// File: rtl/harmonics_ramp.sv
// harmonics_ramp: holds NUM_HARM harmonic amplitudes and glides them toward
// the target table of the most recently loaded voicing. Each update_tick
// moves them one step, so timbre changes do not click.
// Optional build macro: HARMONICS_RAMP_STEP_EN adds a ramp_step input that
// sets the per-tick step size (0 is treated as 1).
module harmonics_ramp #(
    parameter int NUM_HARM = 5,
    parameter int AMP_W    = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2:0]                voicing,
    input  logic                      voicing_valid,
    input  logic                      update_tick,
`ifdef HARMONICS_RAMP_STEP_EN
    input  logic [2:0]                ramp_step,
`endif
    output logic [NUM_HARM*AMP_W-1:0] amplitudes,
    output logic                      busy,
    output logic                      done
);

    localparam int AMP_MAX = (1 << AMP_W) - 1;

    typedef enum logic [0:0] {IDLE, RAMP} state_t;

    state_t             state, state_nxt;
    logic               done_nxt;
    logic [AMP_W-1:0]   amp_p0   [NUM_HARM];
    logic [AMP_W-1:0]   tgt_p0   [NUM_HARM];
    logic [AMP_W-1:0]   amp_nxt  [NUM_HARM];
    logic [AMP_W-1:0]   tgt_nxt  [NUM_HARM];
    logic [AMP_W-1:0]   ld_tgt   [NUM_HARM];
    logic [AMP_W-1:0]   stepped  [NUM_HARM];
    logic               match_ld;
    logic               match_step;
    logic [2:0]         step_sz;

    // Clamp a table entry to the largest amplitude this width can hold.
    function automatic logic [AMP_W-1:0] sat_amp(input int v);
        if (v > AMP_MAX)
            return AMP_W'(AMP_MAX);
        return AMP_W'(v);
    endfunction

    // Target amplitude of harmonic k for a voicing code; unknown codes use NONE.
    function automatic logic [AMP_W-1:0] table_amp(input logic [2:0] code, input int k);
        int v;
        v = 0;
        case (code)
            3'b001: begin
                case (k)
                    0: v = 3;
                    1: v = 2;
                    2: v = 15;
                    3: v = 30;
                    4: v = 15;
                    default: v = 0;
                endcase
            end
            3'b010: begin
                case (k)
                    0: v = 2;
                    1: v = 4;
                    2: v = 10;
                    3: v = 5;
                    default: v = 0;
                endcase
            end
            default: v = (k == 0) ? 1 : 0;
        endcase
        return sat_amp(v);
    endfunction

    // Move cur toward tgt by at most stp; the step is clipped to the remaining
    // distance so the result can neither overshoot nor wrap.
    function automatic logic [AMP_W-1:0] step_amp(input logic [AMP_W-1:0] cur,
                                                  input logic [AMP_W-1:0] tgt,
                                                  input logic [2:0]       stp);
        logic signed [AMP_W+1:0] diff;
        logic signed [AMP_W+1:0] mag;
        logic signed [AMP_W+1:0] lim;
        diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
        lim  = $signed({{(AMP_W-1){1'b0}}, stp});
        mag  = (diff < 0) ? -diff : diff;
        if (mag > lim)
            mag = lim;
        if (diff < 0)
            return cur - AMP_W'(mag);
        return cur + AMP_W'(mag);
    endfunction

`ifdef HARMONICS_RAMP_STEP_EN
    assign step_sz = (ramp_step == 3'd0) ? 3'd1 : ramp_step;
`else
    assign step_sz = 3'd1;
`endif

    // Candidate targets for a load and candidate amplitudes for a tick step.
    always_comb begin
        match_ld   = 1'b1;
        match_step = 1'b1;
        for (int k = 0; k < NUM_HARM; k++) begin
            ld_tgt[k]  = table_amp(voicing, k);
            stepped[k] = step_amp(amp_p0[k], tgt_p0[k], step_sz);
            if (amp_p0[k] != ld_tgt[k])
                match_ld = 1'b0;
            if (stepped[k] != tgt_p0[k])
                match_step = 1'b0;
        end
    end

    // Next-state logic: loads take priority over ticks; ticks only act in RAMP.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        for (int k = 0; k < NUM_HARM; k++) begin
            amp_nxt[k] = amp_p0[k];
            tgt_nxt[k] = tgt_p0[k];
        end
        case (state)
            IDLE: begin
                if (voicing_valid) begin
                    for (int k = 0; k < NUM_HARM; k++)
                        tgt_nxt[k] = ld_tgt[k];
                    if (match_ld)
                        done_nxt = 1'b1;
                    else
                        state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (voicing_valid) begin
                    for (int k = 0; k < NUM_HARM; k++)
                        tgt_nxt[k] = ld_tgt[k];
                    if (match_ld) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (update_tick) begin
                    for (int k = 0; k < NUM_HARM; k++)
                        amp_nxt[k] = stepped[k];
                    if (match_step) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, amplitude and target registers; reset restores the NONE voicing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
            for (int k = 0; k < NUM_HARM; k++) begin
                amp_p0[k] <= table_amp(3'b000, k);
                tgt_p0[k] <= table_amp(3'b000, k);
            end
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            for (int k = 0; k < NUM_HARM; k++) begin
                amp_p0[k] <= amp_nxt[k];
                tgt_p0[k] <= tgt_nxt[k];
            end
        end
    end

    assign busy = (state == RAMP);

    for (genvar g = 0; g < NUM_HARM; g++) begin : g_pack
        assign amplitudes[g*AMP_W +: AMP_W] = amp_p0[g];
    end

endmodule

// File: tb/tb_harmonics_ramp.sv
// Directed bench for harmonics_ramp: default-width instance plus a narrow
// instance (AMP_W=4, NUM_HARM=7) for table saturation.
module tb_harmonics_ramp;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  voicing;
    logic        voicing_valid;
    logic        update_tick;
    logic [29:0] amplitudes;
    logic        busy;
    logic        done;

    logic [2:0]  voicing2;
    logic        voicing_valid2;
    logic        update_tick2;
    logic [27:0] amplitudes2;
    logic        busy2;
    logic        done2;

`ifdef HARMONICS_RAMP_STEP_EN
    logic [2:0]  ramp_step;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    harmonics_ramp #(.NUM_HARM(5), .AMP_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .voicing       (voicing),
        .voicing_valid (voicing_valid),
        .update_tick   (update_tick),
`ifdef HARMONICS_RAMP_STEP_EN
        .ramp_step     (ramp_step),
`endif
        .amplitudes    (amplitudes),
        .busy          (busy),
        .done          (done)
    );

    harmonics_ramp #(.NUM_HARM(7), .AMP_W(4)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .voicing       (voicing2),
        .voicing_valid (voicing_valid2),
        .update_tick   (update_tick2),
`ifdef HARMONICS_RAMP_STEP_EN
        .ramp_step     (ramp_step),
`endif
        .amplitudes    (amplitudes2),
        .busy          (busy2),
        .done          (done2)
    );

    function automatic logic [29:0] p5(input int a, input int b, input int c,
                                       input int d, input int e);
        return {6'(e), 6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] v);
        voicing       = v;
        voicing_valid = 1'b1;
        cyc();
        voicing_valid = 1'b0;
    endtask

    task automatic tick();
        update_tick = 1'b1;
        cyc();
        update_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        voicing        = 3'b000;
        voicing_valid  = 1'b0;
        update_tick    = 1'b0;
        voicing2       = 3'b000;
        voicing_valid2 = 1'b0;
        update_tick2   = 1'b0;
`ifdef HARMONICS_RAMP_STEP_EN
        ramp_step      = 3'd0;
`endif

        // reset then idle
        cyc();
        cyc();
        reset = 1'b1;
        check("rst_amp", amplitudes, p5(1, 0, 0, 0, 0));
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        update_tick = 1'b1;
        repeat (20) cyc();
        update_tick = 1'b0;
        check("idle_tick_amp", amplitudes, p5(1, 0, 0, 0, 0));
        check("idle_tick_busy", busy, 1'b0);
        check("idle_tick_done", done, 1'b0);

        // NONE -> GUITAR, one tick every 4 cycles
        load(3'b001);
        check("g_busy_rise", busy, 1'b1);
        check("g_no_step_yet", amplitudes, p5(1, 0, 0, 0, 0));
        for (int t = 1; t <= 30; t++) begin
            repeat (3) cyc();
            tick();
            if (t == 1) check("g_tick1", amplitudes, p5(2, 1, 1, 1, 1));
            if (t == 29) begin
                check("g_tick29", amplitudes, p5(3, 2, 15, 29, 15));
                check("g_tick29_busy", busy, 1'b1);
                check("g_tick29_done", done, 1'b0);
            end
        end
        check("g_final", amplitudes, p5(3, 2, 15, 30, 15));
        check("g_final_busy", busy, 1'b0);
        check("g_final_done", done, 1'b1);
        cyc();
        check("g_done_drop", done, 1'b0);

        // mid-ramp retarget to FLUTE on a tick cycle
        do_reset();
        load(3'b001);
        repeat (5) tick();
        check("rt_5ticks", amplitudes, p5(3, 2, 5, 5, 5));
        voicing       = 3'b010;
        voicing_valid = 1'b1;
        update_tick   = 1'b1;
        cyc();
        voicing_valid = 1'b0;
        update_tick   = 1'b0;
        check("rt_no_step", amplitudes, p5(3, 2, 5, 5, 5));
        check("rt_busy", busy, 1'b1);
        tick();
        check("rt_tick1", amplitudes, p5(2, 3, 6, 5, 4));
        repeat (3) tick();
        check("rt_tick4_busy", busy, 1'b1);
        tick();
        check("rt_final", amplitudes, p5(2, 4, 10, 5, 0));
        check("rt_final_done", done, 1'b1);
        check("rt_final_busy", busy, 1'b0);

        // same-target load from settled FLUTE
        load(3'b010);
        check("same_busy", busy, 1'b0);
        check("same_done", done, 1'b1);
        cyc();
        check("same_done_drop", done, 1'b0);

        // unknown code falls back to the NONE table
        load(3'b111);
        check("dflt_busy", busy, 1'b1);
        repeat (9) tick();
        check("dflt_tick9_busy", busy, 1'b1);
        tick();
        check("dflt_final", amplitudes, p5(1, 0, 0, 0, 0));
        check("dflt_done", done, 1'b1);

        // reset mid-ramp overrides load and tick
        load(3'b001);
        repeat (3) tick();
        check("rm_3ticks", amplitudes, p5(3, 2, 3, 3, 3));
        reset         = 1'b0;
        update_tick   = 1'b1;
        voicing       = 3'b010;
        voicing_valid = 1'b1;
        cyc();
        update_tick   = 1'b0;
        voicing_valid = 1'b0;
        check("rm_amp", amplitudes, p5(1, 0, 0, 0, 0));
        check("rm_busy", busy, 1'b0);
        check("rm_done", done, 1'b0);
        reset = 1'b1;
        cyc();
        check("rm_after_done", done, 1'b0);

        // retarget in RAMP back to the current amplitudes ends the ramp
        load(3'b001);
        check("back_busy", busy, 1'b1);
        load(3'b000);
        check("back_busy_drop", busy, 1'b0);
        check("back_done", done, 1'b1);
        check("back_amp", amplitudes, p5(1, 0, 0, 0, 0));

        // narrow instance: table values saturate at 15
        do_reset();
        check("w_rst_amp", amplitudes2, 28'h0000001);
        voicing2       = 3'b001;
        voicing_valid2 = 1'b1;
        cyc();
        voicing_valid2 = 1'b0;
        check("w_busy", busy2, 1'b1);
        update_tick2 = 1'b1;
        repeat (14) cyc();
        check("w_tick14", amplitudes2, 28'h00EEE23);
        check("w_tick14_busy", busy2, 1'b1);
        cyc();
        update_tick2 = 1'b0;
        check("w_final", amplitudes2, 28'h00FFF23);
        check("w_final_done", done2, 1'b1);
        check("w_final_busy", busy2, 1'b0);

`ifdef HARMONICS_RAMP_STEP_EN
        // step size 4: NONE -> GUITAR in 8 ticks
        do_reset();
        ramp_step = 3'd4;
        load(3'b001);
        tick();
        check("s4_tick1", amplitudes, p5(3, 2, 4, 4, 4));
        repeat (6) tick();
        check("s4_tick7", amplitudes, p5(3, 2, 15, 28, 15));
        check("s4_tick7_busy", busy, 1'b1);
        tick();
        check("s4_final", amplitudes, p5(3, 2, 15, 30, 15));
        check("s4_done", done, 1'b1);
        ramp_step = 3'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
